// File: rtl/dwt_haar_mac.sv
// Two-stage pipelined Haar lifting unit: {a,b} pixel pair in, {L,H} coefficient pair out.
// Define DWT_MAC_ROUND_EN for round-half-up coefficients; otherwise coefficients truncate.
module dwt_haar_mac #(
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned WIDTH  = 256,
  localparam int unsigned PW = $clog2(WIDTH),
  localparam int unsigned CW = $clog2(HEIGHT * WIDTH / 2) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   i_mac,
  input  logic          i_mac_valid,
  input  logic          i_mac_mode,
  input  logic [PW-1:0] i_mac_row_column_pointer,
  input  logic [PW-1:0] i_mac_pixel_pointer,
  output logic [15:0]   o_mac,
  output logic          o_mac_valid,
  output logic          o_mac_mode,
  output logic [PW-1:0] o_mac_row_column_pointer,
  output logic [PW-1:0] o_mac_pixel_pointer,
  output logic [CW-1:0] o_pair_count
);

  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  // Stage 1: sum / difference plus captured sideband
  logic               s1_valid_q;
  logic [8:0]         s1_sum_q;
  logic signed [8:0]  s1_diff_q;
  logic               s1_mode_q;
  logic [PW-1:0]      s1_rc_q;
  logic [PW-1:0]      s1_pix_q;

  // Stage 2: coefficient pair plus sideband (drives the outputs)
  logic               s2_valid_q;
  logic [15:0]        s2_mac_q;
  logic               s2_mode_q;
  logic [PW-1:0]      s2_rc_q;
  logic [PW-1:0]      s2_pix_q;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               mode_trk_q, mode_trk_d;

  logic [7:0]         l_d;
  logic [7:0]         h_d;

`ifdef DWT_MAC_ROUND_EN
  logic [9:0]         sum_r;
  logic signed [9:0]  diff_r;
  logic signed [9:0]  h_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_diff_q  <= '0;
      s1_mode_q  <= 1'b0;
      s1_rc_q    <= '0;
      s1_pix_q   <= '0;
    end else begin
      s1_valid_q <= i_mac_valid;
      if (i_mac_valid) begin
        s1_sum_q  <= {1'b0, i_mac[15:8]} + {1'b0, i_mac[7:0]};
        s1_diff_q <= $signed({1'b0, i_mac[15:8]} - {1'b0, i_mac[7:0]});
        s1_mode_q <= i_mac_mode;
        s1_rc_q   <= i_mac_row_column_pointer;
        s1_pix_q  <= i_mac_pixel_pointer;
      end
    end
  end

  always_comb begin
    // Offset-binary H: adding 128 to an 8-bit two's-complement value flips its MSB
    l_d = 8'(s1_sum_q >> 1);
    h_d = 8'(s1_diff_q >>> 1) ^ 8'h80;
`ifdef DWT_MAC_ROUND_EN
    sum_r  = {1'b0, s1_sum_q} + 10'd1;
    diff_r = {s1_diff_q[8], s1_diff_q} + 10'sd1;
    h_r    = (diff_r >>> 1) + 10'sd128;
    l_d    = 8'(sum_r >> 1);
    // Only a=255, b=0 reaches 256
    h_d    = (h_r > 10'sd255) ? 8'hFF : h_r[7:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_mac_q   <= '0;
      s2_mode_q  <= 1'b0;
      s2_rc_q    <= '0;
      s2_pix_q   <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_mac_q  <= {l_d, h_d};
        s2_mode_q <= s1_mode_q;
        s2_rc_q   <= s1_rc_q;
        s2_pix_q  <= s1_pix_q;
      end
    end
  end

  // Counter follows the pair entering stage 2 so it updates with o_mac_valid
  always_comb begin
    cnt_d      = cnt_q;
    mode_trk_d = mode_trk_q;
    if (s1_valid_q) begin
      mode_trk_d = s1_mode_q;
      if (s1_mode_q != mode_trk_q) begin
        cnt_d = CW'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      mode_trk_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mode_trk_q <= mode_trk_d;
    end
  end

  assign o_mac                    = s2_mac_q;
  assign o_mac_valid              = s2_valid_q;
  assign o_mac_mode               = s2_mode_q;
  assign o_mac_row_column_pointer = s2_rc_q;
  assign o_mac_pixel_pointer      = s2_pix_q;
  assign o_pair_count             = cnt_q;

endmodule
